// File: rtl/boot_ahb_arbiter.sv
// boot_ahb_arbiter: two-master AHB-Lite arbiter and mux for the shared memory.
// Master 0 is the SPI boot loader and master 1 is the processor core. The loader
// wins arbitration while boot_mode is set and the core wins afterwards. A master
// keeps the bus until it presents IDLE with hmastlock low, so bursts and locked
// sequences are never split.
module boot_ahb_arbiter #(
  parameter logic PARK_MASTER = 1'b1,
  parameter int   AW          = 32,
  parameter int   DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_mode,

  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [2:0]    m0_hburst,
  input  logic [3:0]    m0_hprot,
  input  logic          m0_hmastlock,
  input  logic [DW-1:0] m0_hwdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  output logic [DW-1:0] m0_hrdata,

  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [2:0]    m1_hburst,
  input  logic [3:0]    m1_hprot,
  input  logic          m1_hmastlock,
  input  logic [DW-1:0] m1_hwdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [DW-1:0] m1_hrdata,

  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [2:0]    s_hburst,
  output logic [3:0]    s_hprot,
  output logic          s_hmastlock,
  output logic [DW-1:0] s_hwdata,
  input  logic          s_hready,
  input  logic          s_hresp,
  input  logic [DW-1:0] s_hrdata,

  output logic          grant,
  output logic          dphase_valid,
  output logic          dphase_owner
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic grant_q, grant_d;
  logic dphase_valid_q, dphase_valid_d;
  logic dphase_owner_q, dphase_owner_d;

  logic       m0_req, m1_req;
  logic [1:0] own_htrans;
  logic       own_lock;
  logic       arb_point;

  assign m0_req = m0_htrans[1];
  assign m1_req = m1_htrans[1];

  // Address/control mux: only the granted master ever reaches the slave.
  always_comb begin
    s_haddr     = m0_haddr;
    s_htrans    = m0_htrans;
    s_hwrite    = m0_hwrite;
    s_hsize     = m0_hsize;
    s_hburst    = m0_hburst;
    s_hprot     = m0_hprot;
    s_hmastlock = m0_hmastlock;
    if (grant_q) begin
      s_haddr     = m1_haddr;
      s_htrans    = m1_htrans;
      s_hwrite    = m1_hwrite;
      s_hsize     = m1_hsize;
      s_hburst    = m1_hburst;
      s_hprot     = m1_hprot;
      s_hmastlock = m1_hmastlock;
    end
  end

  // Write data follows the data phase, which lags the address phase by one beat.
  always_comb begin
    s_hwdata = dphase_owner_q ? m1_hwdata : m0_hwdata;
  end

  // Grant may only move when the owner is idle, unlocked and the slave is ready.
  always_comb begin
    own_htrans = grant_q ? m1_htrans : m0_htrans;
    own_lock   = grant_q ? m1_hmastlock : m0_hmastlock;
    arb_point  = s_hready && (own_htrans == HTRANS_IDLE) && !own_lock;
    grant_d    = grant_q;
    if (arb_point) begin
      if (boot_mode) begin
        if (m0_req)      grant_d = 1'b0;
        else if (m1_req) grant_d = 1'b1;
        else             grant_d = 1'b0;
      end else begin
        if (m1_req)      grant_d = 1'b1;
        else if (m0_req) grant_d = 1'b0;
        else             grant_d = PARK_MASTER;
      end
    end
  end

  // Data-phase tracker advances only when the slave completes the current beat.
  always_comb begin
    dphase_valid_d = dphase_valid_q;
    dphase_owner_d = dphase_owner_q;
    if (s_hready) begin
      dphase_valid_d = s_htrans[1];
      dphase_owner_d = grant_q;
    end
  end

  // State registers for grant and the data-phase tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q        <= 1'b0;
      dphase_valid_q <= 1'b0;
      dphase_owner_q <= 1'b0;
    end else begin
      grant_q        <= grant_d;
      dphase_valid_q <= dphase_valid_d;
      dphase_owner_q <= dphase_owner_d;
    end
  end

  // Ready and response steering: the bus owner sees the slave, a waiting requester is stalled.
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    m0_hresp  = 1'b0;
    m1_hresp  = 1'b0;
    if ((dphase_valid_q && !dphase_owner_q) || !grant_q) m0_hready = s_hready;
    else if (m0_req)                                     m0_hready = 1'b0;
    if ((dphase_valid_q && dphase_owner_q) || grant_q)   m1_hready = s_hready;
    else if (m1_req)                                     m1_hready = 1'b0;
    if (dphase_valid_q && !dphase_owner_q) m0_hresp = s_hresp;
    if (dphase_valid_q && dphase_owner_q)  m1_hresp = s_hresp;
  end

  assign m0_hrdata    = s_hrdata;
  assign m1_hrdata    = s_hrdata;
  assign grant        = grant_q;
  assign dphase_valid = dphase_valid_q;
  assign dphase_owner = dphase_owner_q;

endmodule

// File: tb/tb_boot_ahb_arbiter.sv
// Directed testbench for boot_ahb_arbiter: one task per scenario with inline checks.
module tb_boot_ahb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        boot_mode;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hmastlock, m1_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite, s_hmastlock;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [31:0] s_hwdata;
  logic        s_hready, s_hresp;
  logic [31:0] s_hrdata;
  logic        grant, dphase_valid, dphase_owner;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  boot_ahb_arbiter #(.PARK_MASTER(1'b1), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .boot_mode(boot_mode),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .grant(grant), .dphase_valid(dphase_valid), .dphase_owner(dphase_owner)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge so stimulus never races the clock.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_haddr = '0; m0_htrans = IDLE; m0_hwrite = 0; m0_hsize = 3'd2; m0_hburst = 0;
    m0_hprot = 4'h3; m0_hmastlock = 0; m0_hwdata = 32'h0000_00A0;
    m1_haddr = '0; m1_htrans = IDLE; m1_hwrite = 0; m1_hsize = 3'd2; m1_hburst = 0;
    m1_hprot = 4'h3; m1_hmastlock = 0; m1_hwdata = 32'h0000_00B1;
    s_hready = 1; s_hresp = 0; s_hrdata = 32'h1234_5678;
  endtask

  task automatic reset_dut(input logic bm);
    idle_inputs();
    boot_mode = bm;
    #2 reset = 1;
    #7 reset = 0;
    tick();
  endtask

  task automatic test_reset();
    reset_dut(1'b0);
    // grant parked at 1 after the first edge with boot_mode=0
    m1_htrans = NONSEQ; m1_haddr = 32'h40;
    #1;
    tests_run++;
    if (grant !== 1'b1) begin tests_failed++; $display("[TB] FAIL park_grant: got %b expected 1", grant); end
    tick();
    m1_htrans = IDLE;
    #1;
    tests_run++;
    if (dphase_valid !== 1'b1 || dphase_owner !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL m1_dphase: got valid=%b owner=%b expected 1/1", dphase_valid, dphase_owner);
    end
    reset = 1;
    #1;
    tests_run++;
    if (grant !== 1'b0 || dphase_valid !== 1'b0 || dphase_owner !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL async_reset_state: got g=%b v=%b o=%b expected 0/0/0", grant, dphase_valid, dphase_owner);
    end
    tests_run++;
    if (m0_hready !== 1'b1 || m1_hready !== 1'b1 || m0_hresp !== 1'b0 || m1_hresp !== 1'b0 || s_htrans !== IDLE) begin
      tests_failed++; $display("[TB] FAIL reset_outputs: got rdy=%b%b resp=%b%b htrans=%b expected 11 00 00",
                               m0_hready, m1_hready, m0_hresp, m1_hresp, s_htrans);
    end
    reset = 0;
  endtask

  task automatic test_boot_write();
    reset_dut(1'b1);
    m0_htrans = NONSEQ; m0_haddr = 32'h200; m0_hwrite = 1;
    m1_hwdata = 32'h5555_5555;
    #1;
    tests_run++;
    if (s_haddr !== 32'h200 || s_htrans !== NONSEQ || s_hwrite !== 1'b1 || grant !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL boot_addr: got addr=%h htrans=%b wr=%b g=%b expected 200/10/1/0", s_haddr, s_htrans, s_hwrite, grant);
    end
    tick();
    m0_htrans = IDLE; m0_hwrite = 0; m0_hwdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (s_hwdata !== 32'hDEAD_BEEF || dphase_valid !== 1'b1 || dphase_owner !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL boot_wdata: got %h v=%b o=%b expected deadbeef/1/0", s_hwdata, dphase_valid, dphase_owner);
    end
    s_hready = 0;
    #1;
    tests_run++;
    if (m0_hready !== 1'b0) begin tests_failed++; $display("[TB] FAIL boot_hready_low: got %b expected 0", m0_hready); end
    s_hready = 1;
    #1;
    tests_run++;
    if (m0_hready !== 1'b1) begin tests_failed++; $display("[TB] FAIL boot_hready_high: got %b expected 1", m0_hready); end
  endtask

  task automatic test_boot_contention();
    reset_dut(1'b1);
    m0_htrans = NONSEQ; m0_haddr = 32'h200; m0_hburst = 3'd1;
    m1_htrans = NONSEQ; m1_haddr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (s_haddr !== 32'h200 + 32'(4 * i) || m1_hready !== 1'b0 || grant !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL burst_beat%0d: got addr=%h m1rdy=%b g=%b expected %h/0/0",
                                 i, s_haddr, m1_hready, grant, 32'h200 + 32'(4 * i));
      end
      tick();
      m0_htrans = SEQ; m0_haddr = m0_haddr + 4;
    end
    m0_htrans = IDLE;
    #1;
    tests_run++;
    if (grant !== 1'b0 || m1_hready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL burst_release: got g=%b m1rdy=%b expected 0/0", grant, m1_hready);
    end
    tick();
    tests_run++;
    if (grant !== 1'b1 || s_haddr !== 32'h0 || s_htrans !== NONSEQ || m1_hready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL handover: got g=%b addr=%h htrans=%b m1rdy=%b expected 1/0/10/1",
                               grant, s_haddr, s_htrans, m1_hready);
    end
  endtask

  task automatic test_post_boot_priority();
    reset_dut(1'b0);
    m0_htrans = NONSEQ; m0_haddr = 32'h100;
    m1_htrans = NONSEQ; m1_haddr = 32'h300;
    #1;
    tests_run++;
    if (grant !== 1'b1 || s_haddr !== 32'h300 || m0_hready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL core_priority: got g=%b addr=%h m0rdy=%b expected 1/300/0", grant, s_haddr, m0_hready);
    end
    tick();
    m1_htrans = SEQ; m1_haddr = 32'h304;
    #1;
    tests_run++;
    if (grant !== 1'b1 || m0_hready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL core_seq_stall: got g=%b m0rdy=%b expected 1/0", grant, m0_hready);
    end
    tick();
    m1_htrans = IDLE;
    #1;
    tests_run++;
    if (grant !== 1'b1 || m0_hready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL core_idle_stall: got g=%b m0rdy=%b expected 1/0", grant, m0_hready);
    end
    tick();
    tests_run++;
    if (grant !== 1'b0 || s_haddr !== 32'h100 || m0_hready !== 1'b1 || m1_hready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL loader_after_core: got g=%b addr=%h rdy=%b%b expected 0/100/11",
                               grant, s_haddr, m0_hready, m1_hready);
    end
  endtask

  task automatic test_locked();
    reset_dut(1'b0);
    m1_htrans = NONSEQ; m1_haddr = 32'h10; m1_hmastlock = 1;
    m0_htrans = NONSEQ; m0_haddr = 32'h100;
    tick();
    m1_htrans = IDLE;
    tick();
    tests_run++;
    if (grant !== 1'b1 || m0_hready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL lock_idle_hold: got g=%b m0rdy=%b expected 1/0", grant, m0_hready);
    end
    m1_htrans = NONSEQ; m1_haddr = 32'h14;
    #1;
    tests_run++;
    if (s_haddr !== 32'h14 || s_hmastlock !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL lock_second: got addr=%h lock=%b expected 14/1", s_haddr, s_hmastlock);
    end
    tick();
    m1_htrans = IDLE; m1_hmastlock = 0;
    #1;
    tests_run++;
    if (grant !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_end_hold: got %b expected 1", grant); end
    tick();
    tests_run++;
    if (grant !== 1'b0 || s_haddr !== 32'h100) begin
      tests_failed++; $display("[TB] FAIL lock_release: got g=%b addr=%h expected 0/100", grant, s_haddr);
    end
  endtask

  task automatic test_wait_error();
    reset_dut(1'b1);
    m0_htrans = NONSEQ; m0_haddr = 32'h200;
    tick();
    m0_htrans = IDLE;
    m1_htrans = NONSEQ; m1_haddr = 32'h80;
    s_hready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (m0_hready !== 1'b0 || grant !== 1'b0 || m0_hresp !== 1'b0 || m1_hresp !== 1'b0 || dphase_valid !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL wait%0d: got m0rdy=%b g=%b resp=%b%b v=%b expected 0/0/00/1",
                                 i, m0_hready, grant, m0_hresp, m1_hresp, dphase_valid);
      end
      tick();
    end
    s_hresp = 1;
    #1;
    tests_run++;
    if (m0_hresp !== 1'b1 || m0_hready !== 1'b0 || m1_hresp !== 1'b0 || m1_hready !== 1'b0 || grant !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL error1: got resp=%b%b rdy=%b%b g=%b expected 10/00/0",
                               m0_hresp, m1_hresp, m0_hready, m1_hready, grant);
    end
    tick();
    s_hready = 1;
    #1;
    tests_run++;
    if (m0_hresp !== 1'b1 || m0_hready !== 1'b1 || m1_hresp !== 1'b0 || grant !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL error2: got resp=%b%b m0rdy=%b g=%b expected 10/1/0", m0_hresp, m1_hresp, m0_hready, grant);
    end
    tick();
    s_hresp = 0;
    #1;
    tests_run++;
    if (grant !== 1'b1 || m0_hresp !== 1'b0 || dphase_valid !== 1'b0 || s_haddr !== 32'h80) begin
      tests_failed++; $display("[TB] FAIL post_error: got g=%b resp=%b v=%b addr=%h expected 1/0/0/80",
                               grant, m0_hresp, dphase_valid, s_haddr);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut(1'b0);
    m1_htrans = NONSEQ; m1_haddr = 32'hA0; m1_hwrite = 1; m1_hwdata = 32'h1111_1111;
    tick();
    m1_haddr = 32'hA4; m1_hwdata = 32'h2222_2222;
    #1;
    tests_run++;
    if (s_hwdata !== 32'h2222_2222 || dphase_owner !== 1'b1 || s_haddr !== 32'hA4) begin
      tests_failed++; $display("[TB] FAIL b2b_mux: got wdata=%h o=%b addr=%h expected 22222222/1/a4", s_hwdata, dphase_owner, s_haddr);
    end
    tests_run++;
    if (m1_hrdata !== 32'h1234_5678 || m0_hrdata !== 32'h1234_5678) begin
      tests_failed++; $display("[TB] FAIL rdata_fanout: got %h/%h expected 12345678", m0_hrdata, m1_hrdata);
    end
  endtask

  initial begin
    reset = 0;
    boot_mode = 1;
    idle_inputs();
    test_reset();
    test_boot_write();
    test_boot_contention();
    test_post_boot_priority();
    test_locked();
    test_wait_error();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
